// File: rtl/mux_select_arbiter.sv
// Round-robin owner of a shared 4:1 one-bit mux; drives the mux address pins and a one-hot grant.
// Latency: request to grant is 1 cycle from IDLE; every handover inserts exactly one dead (RELEASE) cycle.
// Backpressure: none. The owner keeps the mux while req[owner] stays high. Others wait; no preemption unless the timeout build is enabled.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   req[3:0]   level requests, bit i = requester i wants the mux
//   grant[3:0] registered one-hot grant, 0000 when nobody owns the mux
//   address1/0 registered mux select = current or most recent owner index
//   sel_valid  high only while an owner is granted (equals |grant)
//
// Build option: define MUX_ARB_TIMEOUT_EN to force rotation after HOLD_MAX
// consecutive grant cycles when another requester is waiting. Without it the
// hold counter is not built and HOLD_MAX/CNT_W have no effect.

module mux_select_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       sel_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] last_q, last_d;

    logic       pick_vld;
    logic [1:0] pick_idx;
    logic       force_rel;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Search starts at last+1 and wraps, so `last` itself is considered last.
    // Walking from the farthest offset down lets the nearest requester win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (req[last_q + 2'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = last_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        last_d    = last_q;
        force_rel = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        // Rotate only when someone else is actually waiting.
        force_rel = (cnt_q == HOLD_LAST) && (|(req & ~grant_q));
`endif

        case (state_q)
            IDLE, RELEASE: begin
                grant_d = 4'b0000;
                if (pick_vld) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick_idx;
                    addr_d  = pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req[addr_q] || force_rel) begin
                    // Address is left on the old owner through the dead cycle.
                    state_d = RELEASE;
                    grant_d = 4'b0000;
                    last_d  = addr_q;
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            addr_q  <= 2'd0;
            last_q  <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign address0  = addr_q[0];
    assign address1  = addr_q[1];
    assign sel_valid = (state_q == GRANT);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter: a vector table covering reset,
// single-requester hold, rotation, wrap and pointer behaviour, followed by
// hand-written sequences for constant contention and reset mid-grant.

module tb_mux_select_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       sel_valid;

    int n_checks = 0;
    int n_pass   = 0;

    mux_select_arbiter #(
        .HOLD_MAX(4),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .grant    (grant),
        .address0 (address0),
        .address1 (address1),
        .sel_valid(sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_addr;
        logic       exp_sv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1 ns later.
    task automatic step(input logic rst_n, input logic [3:0] r);
        @(negedge clk);
        reset_n = rst_n;
        req     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [3:0] g, input logic [1:0] a, input logic sv);
        check({tag, "_grant"}, idx, grant, g);
        check({tag, "_addr"}, idx, {2'b00, address1, address0}, {2'b00, a});
        check({tag, "_sel_valid"}, idx, {3'b000, sel_valid}, {3'b000, sv});
    endtask

    task automatic add(input logic rs, input logic [3:0] r, input logic [3:0] g, input logic [1:0] a, input logic sv);
        vec_t v;
        v.rst_n = rs; v.req = r; v.exp_grant = g; v.exp_addr = a; v.exp_sv = sv;
        vecs.push_back(v);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;

        // Reset with all requesting, then rotation 0 -> 1 -> 2 -> 3.
        add(0, 4'b1111, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 4'b0001, 2'd0, 1);
        add(1, 4'b1111, 4'b0001, 2'd0, 1);
        add(1, 4'b1110, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 4'b0010, 2'd1, 1);
        add(1, 4'b1111, 4'b0010, 2'd1, 1);
        add(1, 4'b1101, 4'b0000, 2'd1, 0);
        add(1, 4'b1111, 4'b0100, 2'd2, 1);
        add(1, 4'b1111, 4'b0100, 2'd2, 1);
        add(1, 4'b1011, 4'b0000, 2'd2, 0);
        add(1, 4'b1111, 4'b1000, 2'd3, 1);
        add(1, 4'b1111, 4'b1000, 2'd3, 1);
        // Owner 3 releases, then re-asserts together with 0: 0 wins (wrap).
        add(1, 4'b0001, 4'b0000, 2'd3, 0);
        add(1, 4'b1001, 4'b0001, 2'd0, 1);
        add(1, 4'b1001, 4'b0001, 2'd0, 1);
        add(1, 4'b1000, 4'b0000, 2'd0, 0);
        add(1, 4'b1000, 4'b1000, 2'd3, 1);
        add(1, 4'b0000, 4'b0000, 2'd3, 0);
        add(1, 4'b0000, 4'b0000, 2'd3, 0);
        // Single requester 2 for 5 cycles, release, idle; address stays 10.
        for (int i = 0; i < 5; i++) add(1, 4'b0100, 4'b0100, 2'd2, 1);
        add(1, 4'b0000, 4'b0000, 2'd2, 0);
        add(1, 4'b0000, 4'b0000, 2'd2, 0);
        add(1, 4'b0000, 4'b0000, 2'd2, 0);
        // From IDLE with last=2: 1010 searches 3 first.
        add(1, 4'b1010, 4'b1000, 2'd3, 1);
        add(1, 4'b0010, 4'b0000, 2'd3, 0);
        add(1, 4'b0010, 4'b0010, 2'd1, 1);
        add(1, 4'b0000, 4'b0000, 2'd1, 0);
        add(1, 4'b0000, 4'b0000, 2'd1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req);
            check_all("vec", i, vecs[i].exp_grant, vecs[i].exp_addr, vecs[i].exp_sv);
        end

        // Constant contention 0011 from IDLE with last=1: 0 wins first.
        for (int c = 0; c < 12; c++) begin
            logic [3:0] g;
            logic [1:0] a;
            logic       sv;
`ifdef MUX_ARB_TIMEOUT_EN
            int p;
            p = c % 10;
            if (p < 4)       begin g = 4'b0001; a = 2'd0; sv = 1'b1; end
            else if (p == 4) begin g = 4'b0000; a = 2'd0; sv = 1'b0; end
            else if (p < 9)  begin g = 4'b0010; a = 2'd1; sv = 1'b1; end
            else             begin g = 4'b0000; a = 2'd1; sv = 1'b0; end
`else
            g = 4'b0001; a = 2'd0; sv = 1'b1;
`endif
            step(1, 4'b0011);
            check_all("hold", c, g, a, sv);
        end
        // Both variants end with owner 0 in GRANT; drop everything.
        step(1, 4'b0000);
        check_all("hold_rel", 0, 4'b0000, 2'd0, 0);
        step(1, 4'b0000);
        check_all("hold_idle", 0, 4'b0000, 2'd0, 0);

        // Reset mid-grant with owner 2 (last=0 -> search 1,2 finds 2).
        step(1, 4'b0100);
        check_all("mid_grant", 0, 4'b0100, 2'd2, 1);
        step(1, 4'b0100);
        check_all("mid_grant", 1, 4'b0100, 2'd2, 1);
        step(0, 4'b1110);
        check_all("mid_reset", 0, 4'b0000, 2'd0, 0);
        step(1, 4'b1110);
        check_all("post_reset", 0, 4'b0010, 2'd1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
